// File: rtl/aptag_rank_decoder.sv
// Rank decoder for the APT lookup path: recovers the bitmap position whose inclusive
// set-bit rank equals (apta - li), scanning one chunk of the bitmap per cycle.
module aptag_rank_decoder #(
    parameter int unsigned W = 16,
    parameter int unsigned B = 8,
    parameter int unsigned C = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [W:0]          i_li,
    input  logic [W-1:0]        i_apta,
    input  logic [0:(2**B)-1]   i_data,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_found,
    output logic                o_err,
    output logic [B-1:0]        o_ibpi
);

    localparam int unsigned NB  = 2**B;
    localparam int unsigned NCH = NB / C;
    localparam int unsigned CW  = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW  = B + 1;
    localparam int unsigned DW  = W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [0:NB-1]     r_data;
    logic [B-1:0]      r_target;
    logic [AW-1:0]     r_acc;
    logic [KW-1:0]     r_k;
    logic              r_busy;
    logic              r_done;
    logic              r_found;
    logic              r_err;
    logic [B-1:0]      r_ibpi;

    logic [0:NB-1]     w_data_nxt;
    logic [B-1:0]      w_target_nxt;
    logic [AW-1:0]     w_acc_nxt;
    logic [KW-1:0]     w_k_nxt;
    logic              w_found_nxt;
    logic              w_err_nxt;
    logic [B-1:0]      w_ibpi_nxt;

    logic [DW-1:0]     w_diff;
    logic              w_invalid;
    logic [B-1:0]      w_base;
    logic [B-1:0]      w_idx;
    logic [AW-1:0]     w_run;
    logic              w_hit;
    logic [CW-1:0]     w_j;
    logic [B-1:0]      w_hit_pos;

    // Target rank; MSB of the difference is the borrow, upper bits flag overrange.
    assign w_diff    = {2'b00, i_apta} - {1'b0, i_li};
    assign w_invalid = w_diff[DW-1] || (w_diff == '0) || (w_diff[W:B] != '0);

    assign w_base    = B'(r_k) << CW;
    assign w_hit_pos = w_base | B'(w_j);

    // Running rank across the current chunk; first position reaching the target wins.
    always_comb begin
        w_run = r_acc;
        w_hit = 1'b0;
        w_j   = '0;
        w_idx = '0;
        for (int j = 0; j < int'(C); j++) begin
            w_idx = w_base | B'(j);
            if (r_data[w_idx]) begin
                w_run = w_run + AW'(1);
            end
            if (!w_hit && (w_run == {1'b0, r_target})) begin
                w_hit = 1'b1;
                w_j   = CW'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_data_nxt   = r_data;
        w_target_nxt = r_target;
        w_acc_nxt    = r_acc;
        w_k_nxt      = r_k;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
        w_ibpi_nxt   = r_ibpi;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_found_nxt = 1'b0;
                    w_ibpi_nxt  = '0;
                    if (w_invalid) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_err_nxt    = 1'b0;
                        w_data_nxt   = i_data;
                        w_target_nxt = w_diff[B-1:0];
                        w_acc_nxt    = '0;
                        w_k_nxt      = '0;
                        w_state_nxt  = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    w_found_nxt = 1'b1;
                    w_ibpi_nxt  = w_hit_pos;
                    w_state_nxt = S_DONE;
                end else if (r_k == KW'(NCH - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_acc_nxt = w_run;
                    w_k_nxt   = r_k + KW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // busy/done are registered decodes of the next state so they align with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_target <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_ibpi   <= '0;
        end else begin
            r_data   <= w_data_nxt;
            r_target <= w_target_nxt;
            r_acc    <= w_acc_nxt;
            r_k      <= w_k_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= (w_state_nxt == S_DONE);
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
            r_ibpi   <= w_ibpi_nxt;
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_found = r_found;
    assign o_err   = r_err;
    assign o_ibpi  = r_ibpi;

endmodule

// File: tb/tb_aptag_rank_decoder.sv
// Scoreboard bench for aptag_rank_decoder: directed requests push expected results,
// a monitor pops and compares on every done pulse, including the done cycle index.
module tb_aptag_rank_decoder;

    logic           clk;
    logic           rst;
    logic           i_start;
    logic [16:0]    i_li;
    logic [15:0]    i_apta;
    logic [0:255]   i_data;
    logic           o_busy;
    logic           o_done;
    logic           o_found;
    logic           o_err;
    logic [7:0]     o_ibpi;

    typedef struct {
        logic       found;
        logic       err;
        logic [7:0] ibpi;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    aptag_rank_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_li    (i_li),
        .i_apta  (i_apta),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_found (o_found),
        .o_err   (o_err),
        .o_ibpi  (o_ibpi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_done === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done=1 with empty scoreboard (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("found", 32'(o_found), 32'(e.found));
                    check("err",   32'(o_err),   32'(e.err));
                    check("ibpi",  32'(o_ibpi),  32'(e.ibpi));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // Issue one request; dl is the number of edges after the accept edge until done rises.
    task automatic run(input logic [16:0] li, input logic [15:0] apta, input logic [0:255] d,
                       input logic ef, input logic ee, input logic [7:0] ei, input int dl,
                       input bit poke);
        bit seen;
        @(negedge clk);
        q.push_back('{ef, ee, ei, cyc + 1 + dl});
        i_li    = li;
        i_apta  = apta;
        i_data  = d;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_data  = ~d;
        i_li    = '0;
        i_apta  = '1;
        if (poke) begin
            @(negedge clk);
            check("busy_poke", 32'(o_busy), 32'd1);
            i_start = 1'b1;
            i_apta  = 16'd10;
            @(negedge clk);
            i_start = 1'b0;
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            check("busy", 32'(o_busy), 32'd1);
            if (o_done === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        logic [0:255] d;
        logic [0:255] ones;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        rst     = 1'b1;
        i_start = 1'b0;
        i_li    = '0;
        i_apta  = '0;
        i_data  = '0;
        ones    = '1;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(o_busy),  32'd0);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_found", 32'(o_found), 32'd0);
        check("rst_err",   32'(o_err),   32'd0);
        check("rst_ibpi",  32'(o_ibpi),  32'd0);
        rst = 1'b0;

        // Basic hit: rank 3 is bit 40, in chunk 2.
        d = '0; d[5] = 1'b1; d[20] = 1'b1; d[40] = 1'b1; d[41] = 1'b1;
        run(17'd100, 16'd103, d, 1'b1, 1'b0, 8'd40, 3, 1'b0);

        // Invalid targets: zero, borrow, over range.
        run(17'd10,  16'd10,  d, 1'b0, 1'b1, 8'd0, 0, 1'b0);
        run(17'd200, 16'd50,  d, 1'b0, 1'b1, 8'd0, 0, 1'b0);
        run(17'd0,   16'd256, d, 1'b0, 1'b1, 8'd0, 0, 1'b0);

        // Maximum valid target on an all-ones bitmap, with an ignored start mid-scan.
        run(17'd0, 16'd255, ones, 1'b1, 1'b0, 8'd254, 16, 1'b1);

        // Single set bit 0: rank 2 misses, rank 1 hits immediately.
        d = '0; d[0] = 1'b1;
        run(17'd0, 16'd2, d, 1'b0, 1'b0, 8'd0, 16, 1'b0);
        run(17'd0, 16'd1, d, 1'b1, 1'b0, 8'd0, 1,  1'b0);

        // Last bit position, found in the last chunk.
        d = '0; d[255] = 1'b1;
        run(17'd7, 16'd8, d, 1'b1, 1'b0, 8'd255, 16, 1'b0);

        // Reset during SCAN: everything clears at once and no done follows.
        @(negedge clk);
        i_li    = '0;
        i_apta  = 16'd255;
        i_data  = ones;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(o_busy),  32'd0);
        check("mid_rst_done",  32'(o_done),  32'd0);
        check("mid_rst_found", 32'(o_found), 32'd0);
        check("mid_rst_err",   32'(o_err),   32'd0);
        check("mid_rst_ibpi",  32'(o_ibpi),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fresh request after reset: rank 4 is bit 41.
        d = '0; d[5] = 1'b1; d[20] = 1'b1; d[40] = 1'b1; d[41] = 1'b1;
        run(17'd0, 16'd4, d, 1'b1, 1'b0, 8'd41, 3, 1'b0);

        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
